// File: rtl/wb_mailbox_slave.sv
// Wishbone classic slave with a 32-bit word FIFO mailbox, status/control and a scratch register.
// Each transfer optionally waits WAIT_STATES cycles; all register side effects commit at TERM.
//   state  | meaning
//   S_IDLE | no transfer; waiting for cyc&stb
//   S_WAIT | counting wait states; cyc or stb low aborts
//   S_TERM | ack/err driven; side effects commit at the end of this cycle
module wb_mailbox_slave #(
    parameter int FIFO_AW     = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        int_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TERM} state_t;

    state_t              state_q, state_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [2:0]          idx_q, idx_d;
    logic                we_q, we_d;
    logic [3:0]          sel_q, sel_d;
    logic [31:0]         wdat_q, wdat_d;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic                ie_q, ie_d;
    logic [31:0]         scratch_q, scratch_d;
    logic [31:0]         mem_q [DEPTH];

    logic        req, capture, term, dec_err, empty, full, push;
    logic [7:0]  cnt8;
    logic [31:0] status, rd_data;
    logic        adr_unused;

    assign adr_unused = ^wb_adr_i[1:0];
    assign req        = wb_cyc_i & wb_stb_i;
    assign term       = (state_q == S_TERM);
    assign capture    = req & ~term;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign cnt8       = 8'(count_q);
    assign status     = {16'h0, cnt8, 4'h0, udf_q, ovf_q, full, empty};

    // Data writes must carry all four byte lanes; anything else is refused.
    assign dec_err  = idx_q[2] | ((idx_q == 3'd0) & we_q & (sel_q != 4'hF));
    assign wb_ack_o = term & ~dec_err;
    assign wb_err_o = term & dec_err;
    assign wb_dat_o = rd_data;
    assign int_o    = ie_q & ~empty;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_TERM;
                    end else begin
                        state_d = S_WAIT;
                        wcnt_d  = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (wcnt_q == 4'd0) begin
                    state_d = S_TERM;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_TERM:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The request is re-captured every cycle before TERM, so TERM sees the last sampled values.
    always_comb begin
        idx_d  = capture ? wb_adr_i[4:2] : idx_q;
        we_d   = capture ? wb_we_i : we_q;
        sel_d  = capture ? wb_sel_i : sel_q;
        wdat_d = capture ? wb_dat_i : wdat_q;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;
        ie_d      = ie_q;
        scratch_d = scratch_q;
        push      = 1'b0;
        rd_data   = 32'h0;
        if (wb_ack_o) begin
            case (idx_q)
                3'd0: begin
                    if (we_q) begin
                        if (full) begin
                            ovf_d = 1'b1;
                        end else begin
                            push     = 1'b1;
                            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
                            count_d  = count_q + CW'(1);
                        end
                    end else begin
                        if (empty) begin
                            udf_d = 1'b1;
                        end else begin
                            rd_data  = mem_q[rd_ptr_q];
                            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
                            count_d  = count_q - CW'(1);
                        end
                    end
                end
                3'd1: begin
                    if (!we_q) rd_data = status;
                end
                3'd2: begin
                    if (we_q) begin
                        ie_d = wdat_q[0];
                        if (wdat_q[1]) begin
                            wr_ptr_d = '0;
                            rd_ptr_d = '0;
                            count_d  = '0;
                        end
                        if (wdat_q[2]) begin
                            ovf_d = 1'b0;
                            udf_d = 1'b0;
                        end
                    end else begin
                        rd_data = {31'h0, ie_q};
                    end
                end
                3'd3: begin
                    if (we_q) begin
                        for (int b = 0; b < 4; b++) begin
                            if (sel_q[b]) scratch_d[8*b +: 8] = wdat_q[8*b +: 8];
                        end
                    end else begin
                        rd_data = scratch_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            idx_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            wdat_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            ie_q      <= 1'b0;
            scratch_q <= '0;
        end else begin
            idx_q     <= idx_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            wdat_q    <= wdat_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            ie_q      <= ie_d;
            scratch_q <= scratch_d;
        end
    end

    // Storage needs no reset: it is only visible through count, which resets to zero.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wdat_q;
    end

endmodule

// File: tb/tb_wb_mailbox_slave.sv
// Bench for wb_mailbox_slave: directed vector table, hand-written corner sequences and
// random transfers checked against a queue-based model of the mailbox.
module tb_wb_mailbox_slave;

    localparam int WS    = 3;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic [3:0]  sel_i = '0;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i  = 1'b0;
    logic        ack_o, err_o, int_o;

    always #5 clk = ~clk;

    wb_mailbox_slave #(.FIFO_AW(AW), .WAIT_STATES(WS)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr_i),
        .wb_dat_i (dat_i),
        .wb_dat_o (dat_o),
        .wb_sel_i (sel_i),
        .wb_cyc_i (cyc_i),
        .wb_stb_i (stb_i),
        .wb_we_i  (we_i),
        .wb_ack_o (ack_o),
        .wb_err_o (err_o),
        .int_o    (int_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_q[$];
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;
    logic        m_ie  = 1'b0;
    logic [31:0] m_scratch = '0;

    typedef struct {
        logic [4:0]  adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    function automatic logic [31:0] model_status();
        int n = m_q.size();
        return (32'(n) << 8) | {28'h0, m_udf, m_ovf, (n == DEPTH), (n == 0)};
    endfunction

    function automatic logic model_int();
        return m_ie && (m_q.size() > 0);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_ie = 1'b0;
        m_scratch = '0;
    endtask

    task automatic model_xfer(input logic [4:0] adr, input logic we, input logic [31:0] dat,
                              input logic [3:0] sel, output logic [31:0] rd, output logic err);
        int idx = int'(adr[4:2]);
        rd = '0;
        err = 1'b0;
        if (idx >= 4 || (idx == 0 && we && sel != 4'hF)) begin
            err = 1'b1;
            return;
        end
        case (idx)
            0: begin
                if (we) begin
                    if (m_q.size() == DEPTH) m_ovf = 1'b1;
                    else m_q.push_back(dat);
                end else if (m_q.size() == 0) begin
                    m_udf = 1'b1;
                end else begin
                    rd = m_q.pop_front();
                end
            end
            1: if (!we) rd = model_status();
            2: begin
                if (we) begin
                    m_ie = dat[0];
                    if (dat[1]) m_q.delete();
                    if (dat[2]) begin
                        m_ovf = 1'b0;
                        m_udf = 1'b0;
                    end
                end else begin
                    rd = {31'h0, m_ie};
                end
            end
            default: begin
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) m_scratch[8*b +: 8] = dat[8*b +: 8];
                end else begin
                    rd = m_scratch;
                end
            end
        endcase
    endtask

    // Returns sampled in the TERM cycle (#1 after the edge that entered TERM).
    task automatic wb_xfer(input logic [4:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd, output logic ack,
                           output logic err, output int lat);
        @(posedge clk); #1;
        adr_i = adr; we_i = we; dat_i = dat; sel_i = sel;
        cyc_i = 1'b1; stb_i = 1'b1;
        lat = 0; ack = 1'b0; err = 1'b0; rd = '0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ack_o || err_o) begin
                ack = ack_o;
                err = err_o;
                rd  = dat_o;
                break;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        if (!(ack || err)) begin
            n_total++;
            $display("FAIL xfer timeout: adr %02h no termination within %0d cycles", adr, lat);
        end
    endtask

    task automatic do_op(input string name, input logic [4:0] adr, input logic we,
                         input logic [31:0] dat, input logic [3:0] sel,
                         output logic [31:0] rd_dut, output logic err_dut);
        logic        ack;
        logic [31:0] rd_ref;
        logic        err_ref;
        int          lat;
        wb_xfer(adr, we, dat, sel, rd_dut, ack, err_dut, lat);
        model_xfer(adr, we, dat, sel, rd_ref, err_ref);
        check({name, " latency"}, 32'(lat), 32'(WS + 1));
        check({name, " ack"}, {31'h0, ack}, {31'h0, ~err_ref});
        check({name, " err"}, {31'h0, err_dut}, {31'h0, err_ref});
        if (!we) check({name, " rdata"}, rd_dut, rd_ref);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          n, first, second;
        logic        seen;

        vecs[0]  = '{5'h04, 1'b0, 32'h0,        4'hF, 32'h0000_0001, 1'b0};
        vecs[1]  = '{5'h0C, 1'b0, 32'h0,        4'hF, 32'h0000_0000, 1'b0};
        vecs[2]  = '{5'h0C, 1'b1, 32'hDEADBEEF, 4'h3, 32'h0,         1'b0};
        vecs[3]  = '{5'h0C, 1'b0, 32'h0,        4'hF, 32'h0000_BEEF, 1'b0};
        vecs[4]  = '{5'h00, 1'b1, 32'h11,       4'hF, 32'h0,         1'b0};
        vecs[5]  = '{5'h00, 1'b1, 32'h22,       4'hF, 32'h0,         1'b0};
        vecs[6]  = '{5'h00, 1'b1, 32'h33,       4'hF, 32'h0,         1'b0};
        vecs[7]  = '{5'h04, 1'b0, 32'h0,        4'hF, 32'h0000_0300, 1'b0};
        vecs[8]  = '{5'h00, 1'b0, 32'h0,        4'hF, 32'h11,        1'b0};
        vecs[9]  = '{5'h00, 1'b0, 32'h0,        4'hF, 32'h22,        1'b0};
        vecs[10] = '{5'h00, 1'b0, 32'h0,        4'hF, 32'h33,        1'b0};
        vecs[11] = '{5'h04, 1'b0, 32'h0,        4'hF, 32'h0000_0001, 1'b0};
        vecs[12] = '{5'h00, 1'b1, 32'hAA,       4'h7, 32'h0,         1'b1};
        vecs[13] = '{5'h04, 1'b0, 32'h0,        4'hF, 32'h0000_0001, 1'b0};
        vecs[14] = '{5'h10, 1'b0, 32'h0,        4'hF, 32'h0,         1'b1};
        vecs[15] = '{5'h1C, 1'b1, 32'h5,        4'hF, 32'h0,         1'b1};
        vecs[16] = '{5'h08, 1'b0, 32'h0,        4'hF, 32'h0,         1'b0};
        vecs[17] = '{5'h0B, 1'b1, 32'h1,        4'h0, 32'h0,         1'b0};
        vecs[18] = '{5'h08, 1'b0, 32'h0,        4'hF, 32'h1,         1'b0};
        vecs[19] = '{5'h08, 1'b1, 32'h0,        4'hF, 32'h0,         1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset ack", {31'h0, ack_o}, 32'h0);
        check("reset err", {31'h0, err_o}, 32'h0);
        check("reset dat", dat_o, 32'h0);
        check("reset int", {31'h0, int_o}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel, rd, er);
            check($sformatf("vec%0d err tbl", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
            if (!vecs[i].we) check($sformatf("vec%0d rdata tbl", i), rd, vecs[i].exp_rd);
        end

        // Overflow: 17 pushes into a 16-deep FIFO, then flush plus sticky clear.
        for (int i = 0; i < 17; i++) do_op("fill", 5'h00, 1'b1, 32'(i + 100), 4'hF, rd, er);
        do_op("full status", 5'h04, 1'b0, 32'h0, 4'hF, rd, er);
        check("full status tbl", rd, 32'h0000_1006);
        do_op("flush", 5'h08, 1'b1, 32'h6, 4'hF, rd, er);
        do_op("post flush", 5'h04, 1'b0, 32'h0, 4'hF, rd, er);
        check("post flush tbl", rd, 32'h0000_0001);

        // Interrupt follows ie & ~empty, updating the cycle after TERM.
        do_op("ie set", 5'h08, 1'b1, 32'h1, 4'hF, rd, er);
        do_op("int push", 5'h00, 1'b1, 32'h55, 4'hF, rd, er);
        check("int during term", {31'h0, int_o}, 32'h0);
        @(posedge clk); #1;
        check("int after push", {31'h0, int_o}, 32'h1);
        do_op("int pop", 5'h00, 1'b0, 32'h0, 4'hF, rd, er);
        check("int pop data", rd, 32'h55);
        @(posedge clk); #1;
        check("int after pop", {31'h0, int_o}, 32'h0);
        do_op("udf pop", 5'h00, 1'b0, 32'h0, 4'hF, rd, er);
        check("udf pop data", rd, 32'h0);
        do_op("udf status", 5'h04, 1'b0, 32'h0, 4'hF, rd, er);
        check("udf status tbl", rd, 32'h0000_0009);
        do_op("clr sticky", 5'h08, 1'b1, 32'h4, 4'hF, rd, er);

        // Abort mid-WAIT: no termination and no push.
        @(posedge clk); #1;
        adr_i = 5'h00; we_i = 1'b1; dat_i = 32'hABCD; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        stb_i = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack_o || err_o) seen = 1'b1;
        end
        cyc_i = 1'b0; we_i = 1'b0;
        check("abort no term", {31'h0, seen}, 32'h0);
        do_op("abort status", 5'h04, 1'b0, 32'h0, 4'hF, rd, er);
        check("abort status tbl", rd, 32'h0000_0001);

        // Back-to-back: stb held through termination restarts from IDLE.
        do_op("b2b setup", 5'h0C, 1'b1, 32'hCAFE_F00D, 4'hF, rd, er);
        @(posedge clk); #1;
        adr_i = 5'h0C; we_i = 1'b0; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
        n = 0; first = -1; second = -1;
        while (n < 60 && second < 0) begin
            @(posedge clk); #1;
            n++;
            if (first >= 0 && n == first + 1) check("b2b idle dat", dat_o, 32'h0);
            if (ack_o) begin
                if (first < 0) begin
                    first = n;
                    check("b2b rdata", dat_o, 32'hCAFE_F00D);
                end else begin
                    second = n;
                end
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0;
        check("b2b first latency", 32'(first), 32'(WS + 1));
        check("b2b spacing", 32'(second - first), 32'(WS + 2));

        // Reset mid-transfer: no ack, state back to reset values.
        do_op("rst push", 5'h00, 1'b1, 32'h77, 4'hF, rd, er);
        @(posedge clk); #1;
        adr_i = 5'h00; we_i = 1'b0; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst mid ack", {31'h0, ack_o}, 32'h0);
        check("rst mid int", {31'h0, int_o}, 32'h0);
        @(posedge clk); #1;
        cyc_i = 1'b0; stb_i = 1'b0;
        rst = 1'b0;
        model_reset();
        do_op("rst status", 5'h04, 1'b0, 32'h0, 4'hF, rd, er);
        check("rst status tbl", rd, 32'h0000_0001);
        do_op("rst scratch", 5'h0C, 1'b0, 32'h0, 4'hF, rd, er);
        check("rst scratch tbl", rd, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            int          r;
            logic [4:0]  a;
            logic        w;
            logic [31:0] d;
            logic [3:0]  s;
            r = $urandom_range(0, 15);
            d = $urandom;
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            w = 1'b0;
            if (r <= 5) begin a = 5'h00; w = 1'b1; end
            else if (r <= 8) a = 5'h00;
            else if (r == 9) a = 5'h04;
            else if (r == 10) begin
                a = 5'h08; w = 1'b1;
                d = {29'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1))};
            end
            else if (r == 11) a = 5'h08;
            else if (r <= 13) begin a = 5'h0C; w = 1'($urandom_range(0, 1)); end
            else begin a = 5'($urandom_range(16, 31)); w = 1'($urandom_range(0, 1)); end
            do_op($sformatf("rnd%0d", i), a, w, d, s, rd, er);
            @(posedge clk); #1;
            check($sformatf("rnd%0d int", i), {31'h0, int_o}, {31'h0, model_int()});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
